// File: rtl/amradio_safety_pkg.sv
// Shared types and defaults for the AM carrier safety shutdown path.
// Optional feature macro used by this slice: WD_WARN_ATTENUATE_EN.
package amradio_safety_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RAMP = 2'd2,
        ST_SAFE = 2'd3
    } wd_state_e;

    localparam int DEF_AMP_WIDTH      = 16;
    localparam int DEF_RAMP_STEP      = 256;
    localparam int DEF_TICK_DIV       = 125;
    localparam int DEF_HOLDOFF_CYCLES = 1000;

endpackage

// File: rtl/ramp_tick_gen.sv
// Ramp-rate divider: one-cycle tick every TICK_DIV enabled cycles,
// restarted from zero by a synchronous clear.
module ramp_tick_gen
    import amradio_safety_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rstn || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/wd_shutdown_sequencer.sv
// Watchdog-driven carrier shutdown: ramps amplitude to zero, drops RF, latches fault.
// Optional: WD_WARN_ATTENUATE_EN halves the RUN amplitude while wd_warning is high.
module wd_shutdown_sequencer
    import amradio_safety_pkg::*;
#(
    parameter int AMP_WIDTH      = DEF_AMP_WIDTH,
    parameter int RAMP_STEP      = DEF_RAMP_STEP,
    parameter int TICK_DIV       = DEF_TICK_DIV,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 wd_triggered,
    input  logic                 wd_warning,
    input  logic                 rearm,
    input  logic [AMP_WIDTH-1:0] amp_in,
    output logic [AMP_WIDTH-1:0] amp_out,
    output logic                 rf_enable,
    output logic                 fault_latched,
    output logic [1:0]           state
);

    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [AMP_WIDTH:0] STEP_W = (AMP_WIDTH + 1)'(RAMP_STEP);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLDOFF_CYCLES);

    wd_state_e            r_state, w_state_nxt;
    logic [AMP_WIDTH-1:0] r_amp, w_amp_nxt, w_amp_run, w_amp_dec;
    logic [AMP_WIDTH:0]   w_diff;
    logic                 r_rf, w_rf_nxt;
    logic                 r_fault, w_fault_nxt;
    logic [HW-1:0]        r_hold, w_hold_nxt;
    logic                 w_hold_done, w_tick, w_tick_clr, w_tick_en;

`ifdef WD_WARN_ATTENUATE_EN
    assign w_amp_run = wd_warning ? (amp_in >> 1) : amp_in;
`else
    logic w_unused_warning;
    assign w_unused_warning = wd_warning;
    assign w_amp_run = amp_in;
`endif

    // Extra MSB acts as the borrow flag: set means the step overshot zero.
    assign w_diff    = {1'b0, r_amp} - STEP_W;
    assign w_amp_dec = w_diff[AMP_WIDTH] ? '0 : w_diff[AMP_WIDTH-1:0];

    assign w_hold_done = (r_hold == HOLD_MAX);
    assign w_tick_en   = (r_state == ST_RAMP);
    assign w_tick_clr  = (w_state_nxt == ST_RAMP) && (r_state != ST_RAMP);

    ramp_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rstn   (rstn),
        .i_clr  (w_tick_clr),
        .i_en   (w_tick_en),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_amp_nxt   = r_amp;
        w_fault_nxt = r_fault;
        unique case (r_state)
            ST_IDLE: begin
                w_amp_nxt = '0;
                if (rearm && !wd_triggered) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_amp_nxt = w_amp_run;
                if (wd_triggered) w_state_nxt = ST_RAMP;
            end
            ST_RAMP: begin
                if (r_amp == '0) begin
                    w_state_nxt = ST_SAFE;
                    w_fault_nxt = 1'b1;
                end else if (w_tick) begin
                    w_amp_nxt = w_amp_dec;
                end
            end
            ST_SAFE: begin
                w_amp_nxt = '0;
                if (rearm && w_hold_done && !wd_triggered) begin
                    w_state_nxt = ST_RUN;
                    w_fault_nxt = 1'b0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_rf_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_RAMP);
        // Entry edge counts as the first SAFE cycle.
        w_hold_nxt = '0;
        if (w_state_nxt == ST_SAFE) begin
            w_hold_nxt = w_hold_done ? r_hold : r_hold + HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_amp   <= '0;
            r_rf    <= 1'b0;
            r_fault <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_amp   <= w_amp_nxt;
            r_rf    <= w_rf_nxt;
            r_fault <= w_fault_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    assign amp_out       = r_amp;
    assign rf_enable     = r_rf;
    assign fault_latched = r_fault;
    assign state         = r_state;

endmodule

// File: tb/tb_wd_shutdown_sequencer.sv
// Directed bench for wd_shutdown_sequencer (TICK_DIV=4, RAMP_STEP=256, HOLDOFF=10).
module tb_wd_shutdown_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wd_triggered;
    logic        wd_warning;
    logic        rearm;
    logic [15:0] amp_in;
    logic [15:0] amp_out;
    logic        rf_enable;
    logic        fault_latched;
    logic [1:0]  state;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wd_shutdown_sequencer #(
        .AMP_WIDTH      (16),
        .RAMP_STEP      (256),
        .TICK_DIV       (4),
        .HOLDOFF_CYCLES (10)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .wd_triggered  (wd_triggered),
        .wd_warning    (wd_warning),
        .rearm         (rearm),
        .amp_in        (amp_in),
        .amp_out       (amp_out),
        .rf_enable     (rf_enable),
        .fault_latched (fault_latched),
        .state         (state)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st,
                           input logic [15:0] amp, input logic rf,
                           input logic flt);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".amp"}, 32'(amp_out), 32'(amp));
        chk({tag, ".rf"}, 32'(rf_enable), 32'(rf));
        chk({tag, ".fault"}, 32'(fault_latched), 32'(flt));
    endtask

    initial begin
        rstn = 1'b0;
        wd_triggered = 1'b0;
        wd_warning = 1'b0;
        rearm = 1'b0;
        amp_in = 16'h0;
        cyc(2);
        chk_all("reset", 2'd0, 16'h0, 1'b0, 1'b0);
        rstn = 1'b1;
        cyc(1);

        amp_in = 16'h1000;
        rearm = 1'b1;
        cyc(1);
        rearm = 1'b0;
        chk_all("arm", 2'd1, 16'h0, 1'b1, 1'b0);
        cyc(1);
        chk("run.amp", 32'(amp_out), 32'h1000);

        amp_in = 16'h0300;
        cyc(1);
        chk("run.amp2", 32'(amp_out), 32'h0300);
        wd_triggered = 1'b1;
        cyc(1);
        wd_triggered = 1'b0;
        chk_all("ramp.entry", 2'd2, 16'h0300, 1'b1, 1'b0);
        cyc(3);
        chk("ramp.pre1", 32'(amp_out), 32'h0300);
        cyc(1);
        chk("ramp.t1", 32'(amp_out), 32'h0200);
        cyc(3);
        chk("ramp.pre2", 32'(amp_out), 32'h0200);
        cyc(1);
        chk("ramp.t2", 32'(amp_out), 32'h0100);
        cyc(4);
        chk_all("ramp.zero", 2'd2, 16'h0, 1'b1, 1'b0);
        cyc(1);
        chk_all("safe", 2'd3, 16'h0, 1'b0, 1'b1);

        cyc(4);
        rearm = 1'b1;
        cyc(1);
        rearm = 1'b0;
        chk("safe.rearm5", 32'(state), 32'd3);
        cyc(3);
        rearm = 1'b1;
        cyc(1);
        chk("safe.rearm9", 32'(state), 32'd3);
        cyc(1);
        rearm = 1'b0;
        chk_all("safe.rearm10", 2'd1, 16'h0, 1'b1, 1'b0);
        cyc(1);
        chk("rearm.follow", 32'(amp_out), 32'h0300);

        amp_in = 16'h0080;
        cyc(1);
        wd_triggered = 1'b1;
        cyc(1);
        wd_triggered = 1'b0;
        chk("sat.entry", 32'(amp_out), 32'h0080);
        cyc(4);
        chk("sat.tick", 32'(amp_out), 32'h0000);
        cyc(1);
        chk("sat.safe", 32'(state), 32'd3);

        cyc(12);
        wd_triggered = 1'b1;
        rearm = 1'b1;
        cyc(1);
        rearm = 1'b0;
        wd_triggered = 1'b0;
        chk("safe.trig_rearm", 32'(state), 32'd3);
        chk("safe.trig_fault", 32'(fault_latched), 32'd1);

        rearm = 1'b1;
        cyc(1);
        rearm = 1'b0;
        amp_in = 16'h0500;
        cyc(1);
        chk("run3.amp", 32'(amp_out), 32'h0500);
        wd_triggered = 1'b1;
        cyc(1);
        wd_triggered = 1'b0;
        cyc(4);
        chk("ramp3.t1", 32'(amp_out), 32'h0400);
        rstn = 1'b0;
        cyc(1);
        chk_all("rst.ramp", 2'd0, 16'h0, 1'b0, 1'b0);
        rstn = 1'b1;

        wd_triggered = 1'b1;
        rearm = 1'b1;
        cyc(1);
        rearm = 1'b0;
        wd_triggered = 1'b0;
        chk("idle.trig_rearm", 32'(state), 32'd0);

        rearm = 1'b1;
        cyc(1);
        rearm = 1'b0;
        amp_in = 16'h8000;
        wd_warning = 1'b1;
        cyc(1);
`ifdef WD_WARN_ATTENUATE_EN
        chk("warn.on", 32'(amp_out), 32'h4000);
`else
        chk("warn.on", 32'(amp_out), 32'h8000);
`endif
        wd_warning = 1'b0;
        cyc(1);
        chk("warn.off", 32'(amp_out), 32'h8000);

        amp_in = 16'h0;
        cyc(1);
        wd_triggered = 1'b1;
        cyc(1);
        wd_triggered = 1'b0;
        chk("zero.ramp", 32'(state), 32'd2);
        cyc(1);
        chk_all("zero.safe", 2'd3, 16'h0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wd_shutdown_sequencer.md
# wd_shutdown_sequencer

Downstream consumer of the watchdog timer's `triggered` and `warning` outputs. It gates the AM carrier amplitude path between the host-controlled amplitude register and the DDS/modulator. On watchdog timeout it ramps the amplitude down to zero in controlled steps, then drops the RF enable and latches a fault. Re-arming needs an explicit host request after a hold-off period.

## Interface
Parameters:
- `AMP_WIDTH`, 16: amplitude word width.
- `RAMP_STEP`, 256: amplitude decrement per ramp tick.
- `TICK_DIV`, 125: clk cycles per ramp tick (≥1).
- `HOLDOFF_CYCLES`, 1000: minimum SAFE dwell, in cycles, before re-arm is accepted (≥1).

Ports:
- `clk`  in  1  system clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `wd_triggered`  in  1  watchdog timeout level.
- `wd_warning`  in  1  watchdog pre-timeout warning level.
- `rearm`  in  1  single-cycle host re-arm request.
- `amp_in`  in  AMP_WIDTH  requested carrier amplitude.
- `amp_out`  out  AMP_WIDTH  amplitude to modulator, registered.
- `rf_enable`  out  1  RF output enable, registered.
- `fault_latched`  out  1  timeout shutdown occurred, sticky until re-arm.
- `state`  out  2  FSM state for status readback.

## Operation
- States: IDLE=0, RUN=1, RAMP=2, SAFE=3.
- Reset values: state IDLE, `amp_out` 0, `rf_enable` 0, `fault_latched` 0. Tick and hold-off counters are 0.
- IDLE:
  - `amp_out`=0, `rf_enable`=0.
  - `rearm` && !`wd_triggered` → RUN.
  - `rearm` together with `wd_triggered` is ignored; state stays IDLE.
- RUN:
  - `amp_out`<=`amp_in`; `rf_enable`=1.
  - `wd_triggered` → RAMP.
  - `rearm` is ignored.
- RAMP:
  - `rf_enable`=1.
  - Tick counter counts 0..TICK_DIV-1. On wrap, `amp_out` <= `amp_out` − RAMP_STEP, saturating at 0 (no underflow wrap).
  - `amp_in` is ignored.
  - When `amp_out`==0 → SAFE, checked every cycle, including on entry.
  - Deassertion of `wd_triggered` does not abort the ramp.
- SAFE:
  - `amp_out`=0, `rf_enable`=0, `fault_latched`=1.
  - Hold-off counter increments, saturating at HOLDOFF_CYCLES.
  - `rearm` is accepted only when hold-off is complete && !`wd_triggered`. Then → RUN, `fault_latched` cleared, hold-off counter cleared.
  - An earlier `rearm` is dropped, not queued.
- Reset mid-operation (any state) returns immediately to the reset values. A latched fault is lost on reset; this is intended, since the host re-initialises.
- Arithmetic: subtraction is done at AMP_WIDTH+1 bits; a negative result clamps to 0.

## Timing
- RUN latency `amp_in`→`amp_out`: 1 cycle.
- `wd_triggered` high at edge N (in RUN): state=RAMP after edge N. `amp_out` holds its last RUN value.
- First decrement occurs at edge N+TICK_DIV; subsequent decrements follow every TICK_DIV cycles.
- `amp_out` reaching 0 at edge M: state=SAFE and `rf_enable`=0 after edge M+1.
- SAFE entered at edge S: earliest accepted `rearm` is at edge S+HOLDOFF_CYCLES. State=RUN after that edge, and `amp_out` follows `amp_in` one cycle later.
- Total ramp duration from amplitude A: ceil(A/RAMP_STEP)·TICK_DIV cycles, +1 cycle to SAFE.

## Configuration
- `WD_WARN_ATTENUATE_EN` defined:
  - In RUN with `wd_warning`=1, `amp_out`<=`amp_in`>>1 (−6 dB audible cue to the operator).
  - The full value is restored 1 cycle after `wd_warning` falls.
- Undefined: `wd_warning` is unused and RUN passes `amp_in` unmodified.

## Structure
- Shared package `amradio_safety_pkg`:
  - Enum for the four FSM states with the fixed encodings above.
  - Default localparams for RAMP_STEP, TICK_DIV, HOLDOFF_CYCLES.
- Sub-module `ramp_tick_gen`:
  - Parameterised TICK_DIV divider with synchronous clear.
  - Emits a 1-cycle `tick` pulse.
  - Cleared on RAMP entry.
- FSM, saturating subtractor and hold-off counter live in the top module.

## Test plan
- Reset, then `rearm` with `amp_in`=0x1000 → state RUN; `amp_out`=0x1000 one cycle later; `rf_enable`=1.
- RUN with `amp_in`=0x0300, `wd_triggered` pulse, TICK_DIV=4, RAMP_STEP=256:
  - `amp_out` steps 0x0300→0x0200→0x0100→0x0000 at 4-cycle intervals.
  - SAFE next cycle; `rf_enable`=0; `fault_latched`=1.
- Ramp saturation: RAMP entered with `amp_out`=0x0080, RAMP_STEP=256 → first tick gives 0, not 0xFF80.
- SAFE with HOLDOFF_CYCLES=10:
  - `rearm` at cycle 5 → ignored, state stays SAFE.
  - `rearm` at cycle 10 with `wd_triggered`=0 → RUN, `fault_latched`=0.
- `rearm` in SAFE after hold-off while `wd_triggered`=1 → ignored. `rstn`=0 mid-RAMP → next cycle IDLE, `amp_out`=0, `fault_latched`=0.
- With `WD_WARN_ATTENUATE_EN`: RUN, `amp_in`=0x8000, `wd_warning`=1 → `amp_out`=0x4000. `wd_warning`=0 → 0x8000 one cycle later.
